// File: rtl/bnn_pkg.sv
// Shared constants, FSM encoding and nibble helper for the BNN weight loader.
// Latency: none (types and constants only).
// Backpressure: n/a.
package bnn_pkg;

  localparam int NUM_NEURONS = 20;
  localparam int NIB_W       = 4;
  localparam int BYTE_W      = 2 * NIB_W;
  localparam int IDX_W       = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_LOAD_LO = 3'd2,
    ST_LOAD_HI = 3'd3,
    ST_FIN     = 3'd4
  } state_t;

  // Pick the low or high nibble of a weight byte.
  function automatic logic [NIB_W-1:0] nib_sel(input logic [BYTE_W-1:0] b, input logic hi);
    return hi ? b[BYTE_W-1:NIB_W] : b[NIB_W-1:0];
  endfunction

endpackage

// File: rtl/bnn_load_ctrl_if.sv
// Byte-in / nibble-out bus between the weight source, the loader and the BNN core.
// Latency: none (wires only).
// Backpressure: cfg_ready qualifies cfg_valid; the nibble side has no backpressure.
interface bnn_load_ctrl_if;
  import bnn_pkg::*;

  logic              cfg_valid;
  logic [BYTE_W-1:0] cfg_data;
  logic              cfg_ready;
  logic              load_en;
  logic [NIB_W-1:0]  nib_out;
  logic [IDX_W-1:0]  neuron_idx;

  modport master (
    output cfg_valid, cfg_data,
    input  cfg_ready, load_en, nib_out, neuron_idx
  );

  modport slave (
    input  cfg_valid, cfg_data,
    output cfg_ready, load_en, nib_out, neuron_idx
  );

endinterface

// File: rtl/bnn_byte_fifo.sv
// Small byte FIFO buffering accepted weight bytes ahead of the nibble sequencer.
// Latency: a pushed byte is visible at the head the cycle after the push edge.
// Backpressure: push ignored when full unless a pop frees the slot the same cycle.
module bnn_byte_fifo
  import bnn_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [BYTE_W-1:0] wr_dat,
  input  logic              pop,
  output logic [BYTE_W-1:0] rd_dat,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [BYTE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              bypass;
  logic              do_push;
  logic              do_pop;

  assign full   = (count == (AW+1)'(FIFO_DEPTH));
  assign empty  = (count == '0);
  // Push+pop on an empty FIFO passes the byte straight through and stores nothing.
  assign bypass  = empty && push && pop;
  assign do_push = push && (!full || pop) && !bypass;
  assign do_pop  = pop && !empty;
  assign rd_dat  = empty ? wr_dat : mem[rd_ptr];

  // Storage array; write only, no reset needed since count guards reads.
  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointer and occupancy bookkeeping; clear wins over traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/bnn_load_ctrl.sv
// Reloads NUM_NEURONS weight bytes into the BNN core as lo/hi nibble pairs.
// Latency: byte accepted into an empty FIFO at edge N -> LO nibble N+1, HI nibble N+2.
// Backpressure: cfg_ready drops when FIFO full, reload fully accepted, idle/fin, or ena=0.
module bnn_load_ctrl #(
  parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           start,
  bnn_load_ctrl_if.slave bus,
  output logic           busy,
  output logic           done,
  output logic           err
);
  import bnn_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [IDX_W-1:0] ACC_MAX  = IDX_W'(NUM_NEURONS);

  state_t            state;
  logic [BYTE_W-1:0] hold_byte;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  acc_cnt;
  logic              err_q;

  logic              fifo_clr;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_rd_dat;
  logic              last_pair;
  logic              loading;

  assign last_pair = (idx_q == LAST_IDX);
  assign loading   = (state == ST_LOAD_LO) || (state == ST_LOAD_HI);

  // Accept bytes only while a reload is open and there is room for them.
  assign bus.cfg_ready = ena && (state != ST_IDLE) && (state != ST_FIN)
                         && !fifo_full && (acc_cnt < ACC_MAX);

  assign fifo_clr  = ena && start && (state == ST_IDLE);
  assign fifo_push = bus.cfg_valid && bus.cfg_ready;
  // Pop when waiting for a byte, or back-to-back after a HI nibble that is not the last.
  assign fifo_pop  = ena && !fifo_empty &&
                     ((state == ST_ARMED) || ((state == ST_LOAD_HI) && !last_pair));

  // The core only sees a nibble strobe while enabled, so a stalled pair shows nothing.
  assign bus.load_en    = ena && loading;
  assign bus.nib_out    = bus.load_en ? nib_sel(hold_byte, state == ST_LOAD_HI) : '0;
  assign bus.neuron_idx = idx_q;
  assign busy           = (state != ST_IDLE);
  assign done           = ena && (state == ST_FIN);
  assign err            = err_q;

  bnn_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (fifo_clr),
    .push   (fifo_push),
    .wr_dat (bus.cfg_data),
    .pop    (fifo_pop),
    .rd_dat (fifo_rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Reload sequencer: arms on start, emits lo/hi pairs per byte, pulses FIN at the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold_byte <= '0;
      idx_q     <= '0;
      acc_cnt   <= '0;
      err_q     <= 1'b0;
    end else begin
      // A restart mid-reload is flagged but never disturbs the nibble phase.
      if (start && (state != ST_IDLE)) begin
        err_q <= 1'b1;
      end
      if (ena) begin
        if (fifo_push) begin
          acc_cnt <= acc_cnt + 1'b1;
        end
        case (state)
          ST_IDLE: begin
            if (start) begin
              idx_q   <= '0;
              acc_cnt <= '0;
              err_q   <= 1'b0;
              state   <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (!fifo_empty) begin
              hold_byte <= fifo_rd_dat;
              state     <= ST_LOAD_LO;
            end
          end
          ST_LOAD_LO: begin
            state <= ST_LOAD_HI;
          end
          ST_LOAD_HI: begin
            idx_q <= idx_q + 1'b1;
            if (last_pair) begin
              state <= ST_FIN;
            end else if (!fifo_empty) begin
              hold_byte <= fifo_rd_dat;
              state     <= ST_LOAD_LO;
            end else begin
              state <= ST_ARMED;
            end
          end
          ST_FIN: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
      // A byte offered while idle is a protocol error; it overrides a same-cycle clear.
      if (bus.cfg_valid && (state == ST_IDLE)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bnn_load_ctrl.sv
// Directed bench for bnn_load_ctrl with a nibble scoreboard.
// Latency: n/a.
// Backpressure: bench honours cfg_ready when offering bytes.
module tb_bnn_load_ctrl;
  import bnn_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;
  logic err;

  bnn_load_ctrl_if bus();

  bnn_load_ctrl #(
    .NUM_NEURONS (20),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  int         ld_cnt      = 0;
  int         done_cnt    = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  logic [4:0] idx_model   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every nibble strobe must match the next expected nibble and index.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.load_en) begin
        ld_cnt++;
        if (exp_q.size() == 0) begin
          chk("load_unexpected", 32'(bus.load_en), 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("nibble", 32'(bus.nib_out), 32'(mon_e[8:5]));
          chk("nib_idx", 32'(bus.neuron_idx), 32'(mon_e[4:0]));
        end
      end else begin
        chk("nib_idle_zero", 32'(bus.nib_out), 0);
      end
      if (done) done_cnt++;
    end
  end

  task automatic push_byte(input logic [7:0] b, input int budget, output bit ok, output int stalls);
    ok = 1'b0;
    stalls = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = b;
    for (int i = 0; i < budget && !ok; i++) begin
      #1;
      if (bus.cfg_ready) begin
        ok = 1'b1;
        exp_q.push_back({b[3:0], idx_model});
        exp_q.push_back({b[7:4], idx_model});
        idx_model++;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    bus.cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    chk("done_seen", 32'(done), 1);
  endtask

  task automatic wait_idx(input logic [4:0] v, input int budget);
    int i;
    i = 0;
    while (bus.neuron_idx != v && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    chk("idx_reached", 32'(bus.neuron_idx), 32'(v));
  endtask

  task automatic finish_reload(input string tag);
    wait_done(80);
    @(posedge clk); #1;
    chk({tag, "_idx_final"}, 32'(bus.neuron_idx), 20);
    chk({tag, "_busy_drop"}, 32'(busy), 0);
    chk({tag, "_done_once"}, 32'(done_cnt), 1);
    chk({tag, "_ld_cycles"}, 32'(ld_cnt), 40);
  endtask

  task automatic new_reload();
    pulse_start();
    idx_model = '0;
    ld_cnt    = 0;
    done_cnt  = 0;
  endtask

  initial begin
    bit ok;
    int st;
    int i;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;

    // Reset state
    @(posedge clk); #1;
    chk("rst_load_en", 32'(bus.load_en), 0);
    chk("rst_nib", 32'(bus.nib_out), 0);
    chk("rst_idx", 32'(bus.neuron_idx), 0);
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    ena   = 1'b1;
    @(posedge clk); #1;

    // Full reload with bytes 0x00..0x13 offered back-to-back
    new_reload();
    chk("a_busy", 32'(busy), 1);
    for (int k = 0; k < 20; k++) begin
      push_byte(8'(k), 10, ok, st);
      chk("a_accept", 32'(ok), 1);
      chk("a_stalls", 32'(st), (k < 7) ? 0 : 1);
    end
    push_byte(8'h14, 4, ok, st);
    chk("a_21st_rejected", 32'(ok), 0);
    finish_reload("a");
    chk("a_err", 32'(err), 0);

    // Byte offered while idle
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 8'h3C;
    #1;
    chk("idle_cfg_ready", 32'(bus.cfg_ready), 0);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    chk("idle_byte_err", 32'(err), 1);
    chk("idle_byte_busy", 32'(busy), 0);
    new_reload();
    chk("start_clears_err", 32'(err), 0);

    // Enable stall during LOAD_LO of 0xA5
    push_byte(8'hA5, 10, ok, st);
    chk("s_accept", 32'(ok), 1);
    chk("s_armed_after_accept", 32'(bus.load_en), 0);
    @(posedge clk); #1;
    chk("s_lo_next_cycle", 32'(bus.load_en), 1);
    chk("s_lo_nib", 32'(bus.nib_out), 5);
    ena = 1'b0;
    #1;
    chk("s_stall_load_en", 32'(bus.load_en), 0);
    chk("s_stall_nib", 32'(bus.nib_out), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("s_stall_load_en", 32'(bus.load_en), 0);
      chk("s_stall_busy", 32'(busy), 1);
    end
    ena = 1'b1;
    #1;
    chk("s_resume_lo", 32'(bus.nib_out), 5);
    @(posedge clk); #1;
    chk("s_resume_hi", 32'(bus.nib_out), 'hA);
    for (int k = 1; k < 20; k++) begin
      push_byte(8'($urandom), 10, ok, st);
      chk("s_accept_rest", 32'(ok), 1);
    end
    finish_reload("s");

    // Restart pulse at neuron 7
    new_reload();
    chk("r_err_clear", 32'(err), 0);
    for (int k = 0; k < 8; k++) begin
      push_byte(8'($urandom), 10, ok, st);
      chk("r_accept", 32'(ok), 1);
    end
    wait_idx(5'd7, 40);
    pulse_start();
    chk("r_restart_err", 32'(err), 1);
    chk("r_restart_busy", 32'(busy), 1);
    for (int k = 8; k < 20; k++) begin
      push_byte(8'($urandom), 10, ok, st);
      chk("r_accept", 32'(ok), 1);
    end
    finish_reload("r");
    chk("r_err_sticky", 32'(err), 1);

    // Async reset during LOAD_HI of neuron 3
    new_reload();
    push_byte(8'($urandom), 10, ok, st);
    chk("x_accept", 32'(ok), 1);
    pulse_start();
    chk("x_busy_start_err", 32'(err), 1);
    for (int k = 1; k < 3; k++) begin
      push_byte(8'($urandom), 10, ok, st);
      chk("x_accept", 32'(ok), 1);
    end
    push_byte(8'h9E, 10, ok, st);
    chk("x_accept", 32'(ok), 1);
    i = 0;
    while (!(bus.neuron_idx == 5'd3 && bus.load_en && bus.nib_out == 4'h9) && i < 40) begin
      @(posedge clk); #1;
      i++;
    end
    chk("x_hi3_reached", 32'(bus.nib_out), 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("x_rst_load_en", 32'(bus.load_en), 0);
    chk("x_rst_nib", 32'(bus.nib_out), 0);
    chk("x_rst_idx", 32'(bus.neuron_idx), 0);
    chk("x_rst_cfg_ready", 32'(bus.cfg_ready), 0);
    chk("x_rst_busy", 32'(busy), 0);
    chk("x_rst_done", 32'(done), 0);
    chk("x_rst_err", 32'(err), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("x_post_rst_busy", 32'(busy), 0);
    new_reload();
    chk("x_restart_idx", 32'(bus.neuron_idx), 0);
    for (int k = 0; k < 20; k++) begin
      push_byte(8'($urandom), 10, ok, st);
      chk("x_accept_full", 32'(ok), 1);
    end
    finish_reload("x");
    chk("x_err_final", 32'(err), 0);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
